// File: rtl/traffic_phase_controller.sv
// Traffic phase controller: steps a PIFO test run through warm-up, generate,
// drain and done phases. During the generate phase it shares the single PIFO
// enqueue port among the traffic generators in round-robin order.
module traffic_phase_controller #(
  parameter int NUM_TG       = 4,
  parameter int CNT_W        = 32,
  parameter int PTR_W        = 16,
  parameter int PRIO_W       = 16,
  parameter int DRAIN_CYCLES = 16,
  parameter int SRC_W        = $clog2(NUM_TG)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i__start,
  input  logic [CNT_W-1:0]         i__warmup_cycles,
  input  logic [CNT_W-1:0]         i__generate_cycles,
  input  logic                     i__pifo_ready,
  input  logic [NUM_TG-1:0]        i__tg_valid,
  input  logic [NUM_TG*PTR_W-1:0]  i__tg_pointer,
  input  logic [NUM_TG*PRIO_W-1:0] i__tg_priority,
  output logic                     o__generate_phase,
  output logic [CNT_W-1:0]         o__phase_count,
  output logic [NUM_TG-1:0]        o__tg_ready,
  output logic                     o__pifo_enq_valid,
  output logic [PTR_W-1:0]         o__pifo_enq_pointer,
  output logic [PRIO_W-1:0]        o__pifo_enq_priority,
  output logic [SRC_W-1:0]         o__pifo_enq_source,
  output logic [2:0]               o__state,
  output logic [CNT_W-1:0]         o__enq_count,
  output logic                     o__done
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WARMUP   = 3'd1,
    ST_GENERATE = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  phase_count;
  logic [CNT_W-1:0]  warmup_len;
  logic [CNT_W-1:0]  generate_len;
  logic [CNT_W-1:0]  enq_count;
  logic [SRC_W-1:0]  rr;
  logic              done;
  logic              generate_phase;
  logic              grant;
  logic              enq_valid;
  logic              warmup_last;
  logic              generate_last;
  logic              drain_last;

  // A zero length still occupies one cycle, so zero counts as "last cycle".
  assign warmup_last   = (warmup_len == '0)   || (phase_count == warmup_len - CNT_ONE);
  assign generate_last = (generate_len == '0) || (phase_count == generate_len - CNT_ONE);
  assign drain_last    = (phase_count == DRAIN_LAST);

  // Phase FSM with its phase/enqueue counters and the round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      phase_count  <= '0;
      warmup_len   <= '0;
      generate_len <= '0;
      enq_count    <= '0;
      rr           <= '0;
      done         <= 1'b0;
    end else begin
      if (grant) begin
        rr <= rr + SRC_W'(1);
      end
      if (enq_valid && (enq_count != '1)) begin
        enq_count <= enq_count + CNT_ONE;
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          phase_count <= '0;
          if (i__start) begin
            warmup_len   <= i__warmup_cycles;
            generate_len <= i__generate_cycles;
            enq_count    <= '0;
            state        <= ST_WARMUP;
            done         <= 1'b0;
          end
        end
        ST_WARMUP: begin
          if (warmup_last) begin
            state       <= ST_GENERATE;
            phase_count <= '0;
          end else begin
            phase_count <= phase_count + CNT_ONE;
          end
        end
        ST_GENERATE: begin
          if (generate_last) begin
            state       <= ST_DRAIN;
            phase_count <= '0;
          end else begin
            phase_count <= phase_count + CNT_ONE;
          end
        end
        ST_DRAIN: begin
          if (drain_last) begin
            state       <= ST_DONE;
            phase_count <= '0;
            done        <= 1'b1;
          end else begin
            phase_count <= phase_count + CNT_ONE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          phase_count <= '0;
          done        <= 1'b0;
        end
      endcase
    end
  end

  // Grant and enqueue mux stay combinational: a generator's valid may depend on its ready.
  always_comb begin
    generate_phase       = (state == ST_GENERATE) && (generate_len != '0);
    grant                = generate_phase && i__pifo_ready;
    enq_valid            = 1'b0;
    o__tg_ready          = '0;
    o__pifo_enq_pointer  = '0;
    o__pifo_enq_priority = '0;
    o__pifo_enq_source   = '0;
    for (int k = 0; k < NUM_TG; k++) begin
      if (grant && (rr == SRC_W'(k))) begin
        o__tg_ready[k] = 1'b1;
        if (i__tg_valid[k]) begin
          enq_valid            = 1'b1;
          o__pifo_enq_pointer  = i__tg_pointer[k*PTR_W +: PTR_W];
          o__pifo_enq_priority = i__tg_priority[k*PRIO_W +: PRIO_W];
          o__pifo_enq_source   = SRC_W'(k);
        end
      end
    end
  end

  assign o__generate_phase = generate_phase;
  assign o__pifo_enq_valid = enq_valid;
  assign o__phase_count    = phase_count;
  assign o__state          = state;
  assign o__enq_count      = enq_count;
  assign o__done           = done;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: directed run scenarios with randomized
// generator traffic, compared every cycle against a run-timeline model.
module tb_traffic_phase_controller;

  localparam int NUM_TG = 4;
  localparam int CNT_W  = 32;
  localparam int PTR_W  = 16;
  localparam int PRIO_W = 16;
  localparam int DRAIN  = 16;
  localparam int SRC_W  = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     i__start;
  logic [CNT_W-1:0]         i__warmup_cycles;
  logic [CNT_W-1:0]         i__generate_cycles;
  logic                     i__pifo_ready;
  logic [NUM_TG-1:0]        i__tg_valid;
  logic [NUM_TG*PTR_W-1:0]  i__tg_pointer;
  logic [NUM_TG*PRIO_W-1:0] i__tg_priority;
  logic                     o__generate_phase;
  logic [CNT_W-1:0]         o__phase_count;
  logic [NUM_TG-1:0]        o__tg_ready;
  logic                     o__pifo_enq_valid;
  logic [PTR_W-1:0]         o__pifo_enq_pointer;
  logic [PRIO_W-1:0]        o__pifo_enq_priority;
  logic [SRC_W-1:0]         o__pifo_enq_source;
  logic [2:0]               o__state;
  logic [CNT_W-1:0]         o__enq_count;
  logic                     o__done;

  traffic_phase_controller #(
    .NUM_TG(NUM_TG), .CNT_W(CNT_W), .PTR_W(PTR_W), .PRIO_W(PRIO_W),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk), .reset(reset), .i__start(i__start),
    .i__warmup_cycles(i__warmup_cycles), .i__generate_cycles(i__generate_cycles),
    .i__pifo_ready(i__pifo_ready), .i__tg_valid(i__tg_valid),
    .i__tg_pointer(i__tg_pointer), .i__tg_priority(i__tg_priority),
    .o__generate_phase(o__generate_phase), .o__phase_count(o__phase_count),
    .o__tg_ready(o__tg_ready), .o__pifo_enq_valid(o__pifo_enq_valid),
    .o__pifo_enq_pointer(o__pifo_enq_pointer), .o__pifo_enq_priority(o__pifo_enq_priority),
    .o__pifo_enq_source(o__pifo_enq_source), .o__state(o__state),
    .o__enq_count(o__enq_count), .o__done(o__done)
  );

  // 10-time-unit clock.
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a run is a timeline measured in edges since the start edge.
  int m_started = 0;
  int m_t       = 0;
  int m_w       = 0;
  int m_g       = 0;
  int m_rr      = 0;
  int m_count   = 0;

  // Stimulus knobs.
  bit          start_pending = 0;
  int          pend_w = 0;
  int          pend_g = 0;
  int          valid_mode = 0;
  logic [3:0]  valid_pat = 4'hf;
  int          ready_mode = 0;

  function automatic int eff_w();
    return (m_w == 0) ? 1 : m_w;
  endfunction

  function automatic int eff_g();
    return (m_g == 0) ? 1 : m_g;
  endfunction

  function automatic int exp_state();
    if (m_started == 0) return 0;
    if (m_t <= eff_w()) return 1;
    if (m_t <= eff_w() + eff_g()) return 2;
    if (m_t <= eff_w() + eff_g() + DRAIN) return 3;
    return 4;
  endfunction

  function automatic int exp_pc();
    case (exp_state())
      1: return m_t - 1;
      2: return m_t - eff_w() - 1;
      3: return m_t - eff_w() - eff_g() - 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit exp_grant();
    return (exp_state() == 2) && (m_g != 0) && (i__pifo_ready == 1'b1);
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_t       = 0;
    m_rr      = 0;
    m_count   = 0;
  endtask

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge.
  task automatic applyStimulus();
    if (start_pending) begin
      i__start           = 1'b1;
      i__warmup_cycles   = pend_w;
      i__generate_cycles = pend_g;
      start_pending      = 0;
    end else begin
      i__start           = 1'b0;
      i__warmup_cycles   = $urandom;
      i__generate_cycles = $urandom;
    end
    i__tg_valid    = (valid_mode == 0) ? 4'($urandom) : valid_pat;
    i__tg_pointer  = {$urandom, $urandom};
    i__tg_priority = {$urandom, $urandom};
    case (ready_mode)
      0: i__pifo_ready = 1'b1;
      1: i__pifo_ready = 1'($urandom);
      default: i__pifo_ready = !((exp_state() == 2) && (exp_pc() == 2 || exp_pc() == 3));
    endcase
  endtask

  // Compare every output against the model for the current cycle.
  task automatic checkOutput();
    bit   grant;
    bit   enq;
    int   st;
    logic [3:0] exp_ready;
    st        = exp_state();
    grant     = exp_grant();
    enq       = grant && i__tg_valid[m_rr];
    exp_ready = grant ? (4'b0001 << m_rr) : 4'b0000;
    checkValue("state", o__state, st);
    checkValue("phase_count", o__phase_count, exp_pc());
    checkValue("generate_phase", o__generate_phase, (st == 2) && (m_g != 0));
    checkValue("tg_ready", o__tg_ready, exp_ready);
    checkValue("enq_valid", o__pifo_enq_valid, enq);
    checkValue("enq_pointer", o__pifo_enq_pointer, enq ? i__tg_pointer[m_rr*PTR_W +: PTR_W] : 16'h0);
    checkValue("enq_priority", o__pifo_enq_priority, enq ? i__tg_priority[m_rr*PRIO_W +: PRIO_W] : 16'h0);
    checkValue("enq_source", o__pifo_enq_source, enq ? m_rr : 0);
    checkValue("enq_count", o__enq_count, m_count);
    checkValue("done", o__done, st == 4);
  endtask

  // Advance the model across the coming rising edge.
  task automatic model_update();
    int  st;
    bit  grant;
    st    = exp_state();
    grant = exp_grant();
    if (grant) begin
      if (i__tg_valid[m_rr]) m_count++;
      m_rr = (m_rr + 1) % NUM_TG;
    end
    if (reset == 1'b0) begin
      model_reset();
    end else if ((st == 0 || st == 4) && i__start) begin
      m_started = 1;
      m_t       = 1;
      m_w       = int'(i__warmup_cycles);
      m_g       = int'(i__generate_cycles);
      m_count   = 0;
    end else if (m_started != 0 && st != 4) begin
      m_t++;
    end
  endtask

  task automatic run_cycle();
    applyStimulus();
    #1;
    checkOutput();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic start_run(input int w, input int g);
    start_pending = 1;
    pend_w        = w;
    pend_g        = g;
  endtask

  // Pull reset low part-way into a cycle and check outputs clear before any edge.
  task automatic reset_dut(input int pre_delay, input int cycles);
    #(pre_delay);
    reset = 1'b0;
    #1;
    model_reset();
    checkOutput();
    @(negedge clk);
    run_cycles(cycles);
    reset = 1'b1;
  endtask

  // Directed scenario sequence.
  initial begin
    reset              = 1'b0;
    i__start           = 1'b0;
    i__warmup_cycles   = '0;
    i__generate_cycles = '0;
    i__pifo_ready      = 1'b0;
    i__tg_valid        = '0;
    i__tg_pointer      = '0;
    i__tg_priority     = '0;

    reset_dut(0, 3);
    run_cycles(2);

    $display("[TB] phase sequencing W=3 G=5");
    valid_mode = 0; ready_mode = 0;
    start_run(3, 5);
    run_cycles(1 + 3 + 5 + DRAIN + 3);

    $display("[TB] fair sharing G=8");
    reset_dut(3, 2);
    valid_mode = 1; valid_pat = 4'hf; ready_mode = 0;
    start_run(2, 8);
    run_cycles(1 + 2 + 8 + DRAIN + 2);

    $display("[TB] backpressure in generate cycles 2-3");
    ready_mode = 2;
    start_run(1, 8);
    run_cycles(1 + 1 + 8 + DRAIN + 2);

    $display("[TB] idle generators 0101");
    ready_mode = 0; valid_pat = 4'b0101;
    start_run(2, 8);
    run_cycles(1 + 2 + 8 + DRAIN + 2);

    $display("[TB] zero lengths");
    valid_mode = 0;
    start_run(0, 0);
    run_cycles(1 + 1 + 1 + DRAIN + 2);

    $display("[TB] randomized runs");
    ready_mode = 1;
    for (int r = 0; r < 4; r++) begin
      int w;
      int g;
      w = $urandom_range(0, 4);
      g = $urandom_range(0, 12);
      start_run(w, g);
      run_cycles(1 + ((w == 0) ? 1 : w) + ((g == 0) ? 1 : g) + DRAIN + 2);
    end

    $display("[TB] start during generate is ignored");
    ready_mode = 0; valid_mode = 1; valid_pat = 4'hf;
    start_run(2, 10);
    run_cycles(5);
    start_run(1, 1);
    run_cycles(1 + 10 + DRAIN);

    $display("[TB] reset during generate");
    start_run(2, 10);
    run_cycles(6);
    reset_dut(2, 2);
    run_cycles(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Sequences a PIFO testbench run through warm-up, generate, drain and done phases. Round-robin shares a single PIFO enqueue port among `NUM_TG` traffic generators. Drives each generator's generate-phase, phase-count and ready inputs, and muxes the granted generator's packet onto the PIFO enqueue port. Sits between the traffic generators and the PIFO under test; the scoreboard reads its enqueue count and done flag.

## Interface
- `NUM_TG`, 4: number of traffic generators; power of two, ≥2.
- `CNT_W`, 32: width of cycle/packet counters.
- `PTR_W`, 16: packet pointer width.
- `PRIO_W`, 16: priority width.
- `DRAIN_CYCLES`, 16: fixed drain-phase length in cycles, ≥1.
- `SRC_W`, $clog2(NUM_TG): source index width (derived).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i__start`  in  1  run start; honoured only in IDLE or DONE.
- `i__warmup_cycles`  in  CNT_W  warm-up length; latched on accepted start.
- `i__generate_cycles`  in  CNT_W  generate length; latched on accepted start.
- `i__pifo_ready`  in  1  PIFO can accept an enqueue this cycle.
- `i__tg_valid`  in  NUM_TG  per-generator packet valid.
- `i__tg_pointer`  in  NUM_TG*PTR_W  packed pointers; generator k occupies bits [k*PTR_W +: PTR_W].
- `i__tg_priority`  in  NUM_TG*PRIO_W  packed priorities, same packing.
- `o__generate_phase`  out  1  broadcast generate-phase flag.
- `o__phase_count`  out  CNT_W  cycles elapsed in current phase.
- `o__tg_ready`  out  NUM_TG  per-generator grant; one-hot or zero.
- `o__pifo_enq_valid`  out  1  enqueue strobe to the PIFO.
- `o__pifo_enq_pointer`  out  PTR_W  pointer of the granted generator.
- `o__pifo_enq_priority`  out  PRIO_W  priority of the granted generator.
- `o__pifo_enq_source`  out  SRC_W  granted generator index.
- `o__state`  out  3  IDLE=0, WARMUP=1, GENERATE=2, DRAIN=3, DONE=4.
- `o__enq_count`  out  CNT_W  enqueues in current run.
- `o__done`  out  1  high while in DONE.

## Operation
- Reset asserted (low): state IDLE, all counters and the round-robin pointer cleared, every output 0. Takes effect immediately, independent of `clk`.
- FSM:
  - IDLE / DONE: on `i__start`=1, latch both lengths, clear `o__enq_count`, go to WARMUP.
  - WARMUP: lasts max(W,1) cycles, where W is the latched warm-up length.
  - GENERATE: lasts max(G,1) cycles, where G is the latched generate length.
  - DRAIN: lasts `DRAIN_CYCLES` cycles.
  - DONE: holds until the next `i__start`.
- `i__start` in any other state is ignored. Latched lengths are unaffected by input changes mid-run.
- `o__phase_count`: 0 on the first cycle of each phase, +1 per cycle, reset to 0 on phase change. In IDLE and DONE it holds 0.
- `o__generate_phase` = (state==GENERATE) && (G≠0).
- Grant: when `o__generate_phase` && `i__pifo_ready`, `o__tg_ready` = one-hot at round-robin pointer `rr`; otherwise 0.
- `rr` advances (mod NUM_TG) on every cycle a grant is issued, whether or not the granted generator is valid. It holds otherwise and persists across runs; only reset clears it.
- `o__pifo_enq_valid` = (grant issued) && `i__tg_valid[rr]`. This path is combinational because a generator's valid depends combinationally on its ready.
- `o__pifo_enq_pointer`, `o__pifo_enq_priority` and `o__pifo_enq_source` carry generator `rr`'s fields when valid; they are 0 otherwise.
- `o__enq_count` increments on each `o__pifo_enq_valid` and saturates at all-ones.
- Valid from an ungranted generator is ignored; no error is flagged.

## Timing
- `i__start` sampled at edge t: `o__state`=WARMUP from cycle t+1.
- State, `o__phase_count`, `o__enq_count`, `rr` and `o__done` are registered.
- Grant and enqueue outputs are combinational from current state, `rr`, `i__pifo_ready` and `i__tg_valid`: zero-cycle latency.
- Total run length from start to first DONE cycle = max(W,1) + max(G,1) + DRAIN_CYCLES.
- `i__pifo_ready`=0 for k cycles: no grants and no `rr` movement; the generate phase still elapses.
- Last GENERATE cycle can grant. The first DRAIN cycle cannot.

## Test plan
- Reset: hold reset low 3 cycles, then release → all outputs 0, `o__state`=0. Assert reset low mid-cycle → outputs 0 without waiting for a clock edge.
- Phase sequencing: W=3, G=5, DRAIN_CYCLES=16, start at cycle 0 → `o__generate_phase` high in cycles 4–8 with `o__phase_count` 0..4; DRAIN in cycles 9–24; `o__done`=1 from cycle 25.
- Fair sharing: all `i__tg_valid`=1, `i__pifo_ready`=1, G=8 → `o__pifo_enq_source` sequence 0,1,2,3,0,1,2,3; `o__enq_count`=8 at DONE.
- Backpressure and idle generators:
  - `i__pifo_ready`=0 for generate cycles 2–3 → `o__tg_ready`=0 for those cycles; sources 0,1,2,3,0,1 for G=8; count=6.
  - `i__tg_valid`=4'b0101 with ready high → enqueues only from sources 0 and 2; `rr` still steps through 1 and 3.
- Zero lengths: W=0, G=0 → WARMUP and GENERATE last 1 cycle each; `o__generate_phase` never high; count 0; DONE after 18 cycles.
- Restart and abort:
  - Start from DONE → count clears and the run repeats.
  - Start during GENERATE → ignored.
  - Reset during GENERATE → IDLE, all outputs 0; a new start is required to run again.
